shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for one shared W-bit flop register.
//   N requesters use a req/gnt handshake; only the granted requester can write.
//   A force/release override pins the register to a value. It takes priority over every grant.
//   Sits in front of the team's flop primitives as their write/force controller.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   DW       8   register data width
//   MAX_HOLD 16  max GRANT cycles before forced release (only with SRA_TIMEOUT_EN)
//   RST_VAL  0   register value after reset
// PORTS
//   clk           in   1         clock, all logic on posedge
//   rst           in   1         synchronous reset, active-high
//   req           in   N_REQ     per-requester access request, level
//   wr_en         in   N_REQ     per-requester write strobe
//   wr_data       in   N_REQ*DW  write data, requester i at [i*DW +: DW]
//   force_en      in   1         override: hold q at force_val while high
//   force_val     in   DW        override value
//   gnt           out  N_REQ     one-hot grant, registered
//   q             out  DW        shared register contents
//   busy          out  1         1 when state != IDLE
//   timeout_pulse out  1         1-cycle pulse on forced release
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, q=RST_VAL, gnt=0, busy=0, timeout_pulse=0, rr_ptr=0.
//   States: IDLE, GRANT, FORCED. busy=(state!=IDLE).
//   IDLE->FORCED when force_en=1. Else IDLE->GRANT when any eligible req=1.
//     gnt goes to the first eligible requester at or after rr_ptr, wrapping N_REQ-1 -> 0.
//     gnt rises 1 cycle after req is sampled.
//   GRANT (gnt[i]=1): wr_en[i]=1 loads q<=wr_data[i] at the next edge. wr_en of ungranted requesters is ignored.
//     req[i]=0 -> next edge: gnt=0, state=IDLE, rr_ptr=(i+1)%N_REQ.
//     Always 1 dead IDLE cycle between grants.
//   force_en=1 in any state -> next edge: q<=force_val, gnt=0, state=FORCED.
//     Same-cycle writes are discarded. An active grant is revoked and rr_ptr advances past it.
//   FORCED: q<=force_val every cycle. force_en=0 -> state=IDLE and q keeps the last force_val.
//   Simultaneous reqs: lowest index at or after rr_ptr wins. Others wait with no queueing state.
//   rst mid-grant or mid-force dominates everything.
// CONFIGURATION
//   SRA_TIMEOUT_EN defined:
//     hold_cnt clears on GRANT entry and increments each GRANT cycle.
//     When hold_cnt==MAX_HOLD-1 and req[i] is still 1:
//       - next edge: gnt=0, timeout_pulse=1 for 1 cycle, state=IDLE, rr_ptr=(i+1)%N_REQ.
//       - requester i is locked out (ineligible) until it drops req[i] for at least 1 cycle.
//     A write in the final grant cycle still takes effect.
//   SRA_TIMEOUT_EN undefined:
//     No counter and no lockout. Grant is held while req stays high. timeout_pulse tied 0.
// TESTING
//   1. rst=1 two cycles, then req=0 -> q=RST_VAL, gnt=0, busy=0.
//   2. req=4'b0001; at gnt[0] drive wr_en[0]=1 with data 8'hA5; drop req
//      -> q=8'hA5 next cycle, gnt=0 one cycle later.
//   3. req=4'b1111 held, each requester releases after one write
//      -> grant order 0,1,2,3,0 with 1 IDLE cycle between grants.
//   4. During gnt[2] with wr_en[2]=1 and data 8'h11, raise force_en with force_val=8'h3C
//      -> q=8'h3C, gnt=0, state FORCED; drop force_en -> q stays 8'h3C, IDLE.
//   5. SRA_TIMEOUT_EN with MAX_HOLD=16: req[1] held high
//      -> gnt[1] high exactly 16 cycles, then timeout_pulse=1, and req[1] not regranted until toggled.
//   6. Assert rst during GRANT with q=8'h77 -> next cycle q=RST_VAL, gnt=0, rr_ptr=0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter and force/release sequencer
// for one shared DW-bit register. N_REQ requesters use a level req with a
// registered one-hot gnt. Only the granted requester may load the register.
// A force override pins the register to force_val and beats any grant.
//
// Optional feature macro: SRA_TIMEOUT_EN
//   When defined, a grant that has been held for MAX_HOLD cycles is revoked.
//   timeout_pulse fires for one cycle. The offending requester is then locked
//   out until it drops req for at least one cycle.
//   When undefined, a grant is held for as long as req stays high, and
//   timeout_pulse is tied low.
module shared_reg_arbiter #(
    parameter int            N_REQ    = 4,
    parameter int            DW       = 8,
    parameter int            MAX_HOLD = 16,
    parameter logic [DW-1:0] RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    wr_en,
    input  logic [N_REQ*DW-1:0] wr_data,
    input  logic                force_en,
    input  logic [DW-1:0]       force_val,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       q,
    output logic                busy,
    output logic                timeout_pulse
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_FORCED = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    cur;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;
    logic [PW:0]      cand;
    logic             cur_req;
    logic             cur_wr;
    logic [DW-1:0]    cur_data;
    logic             timeout_hit;

    // Round-robin successor, wrapping N_REQ-1 back to 0 for any N_REQ.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (i == PW'(N_REQ - 1)) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    assign busy = (state != ST_IDLE);

    // Select the first eligible requester at or after rr_ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(N_REQ)) begin
                cand = cand - (PW+1)'(N_REQ);
            end
            if (!pick_vld && eligible[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PW-1:0];
            end
        end
        if (pick_vld) begin
            pick_oh[pick_idx] = 1'b1;
        end
    end

    // Current owner's request, write strobe and data, selected by the one-hot gnt.
    always_comb begin
        cur_req  = |(req & gnt);
        cur_wr   = |(wr_en & gnt);
        cur_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                cur_data = wr_data[k*DW +: DW];
            end
        end
    end

`ifdef SRA_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0]    hold_cnt;
    logic [N_REQ-1:0] lock;
    logic             to_take;

    assign eligible    = req & ~lock;
    assign timeout_hit = cur_req && (hold_cnt == CW'(MAX_HOLD - 1));
    assign to_take     = (state == ST_GRANT) && !force_en && timeout_hit;

    // Hold counter, lockout mask and one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt      <= '0;
            lock          <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= to_take;
            if (state == ST_GRANT) begin
                hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end
            // A locked requester becomes eligible again once it drops req.
            lock <= (lock & req) | (to_take ? gnt : '0);
        end
    end
`else
    assign eligible      = req;
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Main sequencer: grant and release, force override, and register loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            q      <= RST_VAL;
            gnt    <= '0;
            cur    <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (force_en) begin
                        state <= ST_FORCED;
                        q     <= force_val;
                    end else if (pick_vld) begin
                        state <= ST_GRANT;
                        gnt   <= pick_oh;
                        cur   <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (force_en) begin
                        // The force discards the owner's same-cycle write and revokes the grant.
                        state  <= ST_FORCED;
                        q      <= force_val;
                        gnt    <= '0;
                        rr_ptr <= next_idx(cur);
                    end else begin
                        if (cur_wr) begin
                            q <= cur_data;
                        end
                        if (!cur_req || timeout_hit) begin
                            state  <= ST_IDLE;
                            gnt    <= '0;
                            rr_ptr <= next_idx(cur);
                        end
                    end
                end
                ST_FORCED: begin
                    if (force_en) begin
                        q <= force_val;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Testbench for shared_reg_arbiter: directed scenarios followed by random
// traffic. All outputs are compared every cycle against a behavioural model.
module tb_shared_reg_arbiter;

    localparam int            N        = 4;
    localparam int            DW       = 8;
    localparam int            MAX_HOLD = 16;
    localparam logic [DW-1:0] RST_VAL  = 8'h00;
`ifdef SRA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    wr_en;
    logic [N*DW-1:0] wr_data;
    logic            force_en;
    logic [DW-1:0]   force_val;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic            busy;
    logic            timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: who owns the register (-1 = nobody), force active, pointer.
    int            owner;
    bit            forcing;
    int            ptr;
    logic [DW-1:0] mq;
    bit            mpulse;
    int            held;
    bit [N-1:0]    locked;

    shared_reg_arbiter #(
        .N_REQ(N), .DW(DW), .MAX_HOLD(MAX_HOLD), .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .wr_data(wr_data),
        .force_en(force_en), .force_val(force_val), .gnt(gnt), .q(q),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        if (rst) begin
            owner = -1; forcing = 0; ptr = 0; mq = RST_VAL;
            mpulse = 0; held = 0; locked = '0;
            return;
        end
        mpulse = 0;
        for (int i = 0; i < N; i++) if (!req[i]) locked[i] = 0;
        if (forcing) begin
            if (force_en) mq = force_val;
            else forcing = 0;
        end else if (owner >= 0) begin
            if (force_en) begin
                mq = force_val; ptr = (owner + 1) % N; owner = -1; forcing = 1;
            end else begin
                held++;
                if (wr_en[owner]) mq = wr_data[owner*DW +: DW];
                if (!req[owner]) begin
                    ptr = (owner + 1) % N; owner = -1;
                end else if (TO_EN && held == MAX_HOLD) begin
                    mpulse = 1; locked[owner] = 1; ptr = (owner + 1) % N; owner = -1;
                end
            end
        end else begin
            if (force_en) begin
                forcing = 1; mq = force_val;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (ptr + k) % N;
                    if (owner < 0 && req[i] && !locked[i]) begin
                        owner = i; held = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        model_step();
        @(posedge clk);
        #1;
        eg = (owner >= 0) ? (N'(1) << owner) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("q", 32'(q), 32'(mq));
        chk("busy", 32'(busy), 32'(owner >= 0 || forcing));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(mpulse));
    endtask

    // Tick until some grant is visible; an expired bound counts as a failure.
    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (gnt == '0 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_gnt_timeout"}, 32'(gnt != '0), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; req = '0; wr_en = '0; wr_data = '0;
        force_en = 1'b0; force_val = '0;
        owner = -1; forcing = 0; ptr = 0; mq = RST_VAL; mpulse = 0; held = 0; locked = '0;

        // 1: reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t1_q", 32'(q), 32'(RST_VAL));
        chk("t1_gnt", 32'(gnt), 32'(0));
        chk("t1_busy", 32'(busy), 32'(0));

        // 2: single requester writes A5, then releases
        req = 4'b0001;
        tick();
        chk("t2_gnt0", 32'(gnt), 32'(4'b0001));
        wr_en = 4'b0001; wr_data[7:0] = 8'hA5;
        tick();
        chk("t2_q", 32'(q), 32'h A5);
        wr_en = '0; req = '0;
        tick();
        chk("t2_gnt_off", 32'(gnt), 32'(0));

        // 3: all requesting, each releases after one write -> 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int idx;
            idx = k % N;
            wait_gnt("t3");
            chk("t3_order", 32'(gnt), 32'(N'(1) << idx));
            wr_en = N'(1) << idx;
            wr_data[idx*DW +: DW] = 8'(8'h20 + k);
            tick();
            chk("t3_q", 32'(q), 32'(8'h20 + k));
            wr_en = '0;
            req[idx] = 1'b0;
            tick();
            chk("t3_dead_gnt", 32'(gnt), 32'(0));
            chk("t3_dead_busy", 32'(busy), 32'(0));
            req[idx] = 1'b1;
            tick();
        end
        req = '0;
        tick(); tick();

        // 4: force during gnt[2] beats a same-cycle write
        do_reset();
        req = 4'b0100;
        wait_gnt("t4");
        chk("t4_gnt2", 32'(gnt), 32'(4'b0100));
        wr_en = 4'b0100; wr_data[23:16] = 8'h11;
        force_en = 1'b1; force_val = 8'h3C;
        tick();
        chk("t4_q_forced", 32'(q), 32'h3C);
        chk("t4_gnt_forced", 32'(gnt), 32'(0));
        chk("t4_busy_forced", 32'(busy), 32'(1));
        force_en = 1'b0; wr_en = '0; force_val = 8'h99;
        tick();
        chk("t4_q_hold", 32'(q), 32'h3C);
        chk("t4_busy_idle", 32'(busy), 32'(0));
        req = '0;
        tick(); tick();

        // 5: long hold on requester 1
        do_reset();
        req = 4'b0010;
        tick();
        cnt = 0;
        while (gnt[1] && cnt < 40) begin
            cnt++;
            tick();
        end
`ifdef SRA_TIMEOUT_EN
        chk("t5_hold_cycles", 32'(cnt), 32'(MAX_HOLD));
        chk("t5_pulse", 32'(timeout_pulse), 32'(1));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_locked", 32'(gnt), 32'(0));
        end
        req = '0;
        tick();
        req = 4'b0010;
        tick(); tick();
        chk("t5_regrant", 32'(gnt), 32'(4'b0010));
`else
        chk("t5_hold_cycles", 32'(cnt), 32'(40));
        chk("t5_no_pulse", 32'(timeout_pulse), 32'(0));
`endif
        req = '0;
        tick(); tick();

        // 6: reset mid-grant restores q, gnt and the pointer
        do_reset();
        req = 4'b0010;
        wait_gnt("t6a");
        req = '0;
        tick(); tick();
        req = 4'b0100;
        wait_gnt("t6b");
        wr_en = 4'b0100; wr_data[23:16] = 8'h77;
        tick();
        chk("t6_q77", 32'(q), 32'h77);
        wr_en = '0;
        rst = 1'b1;
        tick();
        chk("t6_q_rst", 32'(q), 32'(RST_VAL));
        chk("t6_gnt_rst", 32'(gnt), 32'(0));
        rst = 1'b0; req = 4'b1111;
        tick();
        chk("t6_ptr0", 32'(gnt), 32'(4'b0001));
        req = '0;
        tick(); tick();

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            req       = 4'($urandom);
            wr_en     = 4'($urandom);
            wr_data   = $urandom;
            force_en  = ($urandom_range(0, 15) == 0);
            force_val = 8'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            if (c % 100 < 40) req = 4'b0011 | req;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
